// File: rtl/memory_arbiter_if.sv
// Cache-side and RAM-side signals of the shared memory arbiter.
// slave: the arbiter itself; master: the caches plus RAM model that drive it.
interface memory_arbiter_if #(
  parameter int unsigned CPUS = 2
);
  logic [CPUS-1:0]        iREN;
  logic [CPUS-1:0]        dREN;
  logic [CPUS-1:0]        dWEN;
  logic [CPUS-1:0][31:0]  iaddr;
  logic [CPUS-1:0][31:0]  daddr;
  logic [CPUS-1:0][31:0]  dstore;
  logic [CPUS-1:0]        iwait;
  logic [CPUS-1:0]        dwait;
  logic [CPUS-1:0][31:0]  iload;
  logic [CPUS-1:0][31:0]  dload;
  logic                   ramREN;
  logic                   ramWEN;
  logic [31:0]            ramaddr;
  logic [31:0]            ramstore;
  logic [31:0]            ramload;
  logic [1:0]             ramstate;

  modport slave (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates the single RAM port among per-CPU icache/dcache requesters.
// Define MEMARB_RR_EN for round-robin within a class; otherwise fixed lowest-index priority.
module memory_arbiter #(
  parameter int unsigned CPUS    = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  memory_arbiter_if.slave   bus,
  output logic              timeout_err
);

  localparam int unsigned CW = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_ERROR  = 2'd3
  } ramstate_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   r_grant_cpu;
  logic            r_grant_is_d;
  logic            r_grant_valid;
  logic [7:0]      r_cnt;
  logic            r_timeout_err;

  logic [CPUS-1:0] w_dreq;
  logic [CPUS-1:0] w_cand;
  logic            w_any_d;
  logic [CW-1:0]   w_start;
  logic [CW-1:0]   w_pick;
  logic            w_found;
  logic            w_busy;
  logic            w_access;
  logic            w_g_req;
  logic            w_withdraw;
  logic            w_tmo;

  assign w_dreq  = bus.dREN | bus.dWEN;
  assign w_any_d = |w_dreq;
  assign w_cand  = w_any_d ? w_dreq : bus.iREN;

`ifdef MEMARB_RR_EN
  logic [CW-1:0] r_rr;
  logic [CW-1:0] w_rr_next;

  assign w_rr_next = (32'(r_grant_cpu) == CPUS - 1) ? '0 : r_grant_cpu + CW'(1);
  assign w_start   = r_rr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rr <= '0;
    end else if (w_access || w_tmo) begin
      r_rr <= w_rr_next;
    end
  end
`else
  assign w_start = '0;
`endif

  // Circular search: first pass covers start..CPUS-1, second pass wraps to 0..start-1.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int unsigned k = 0; k < CPUS; k++) begin
      if (!w_found && w_cand[k] && (k >= 32'(w_start))) begin
        w_found = 1'b1;
        w_pick  = CW'(k);
      end
    end
    for (int unsigned k = 0; k < CPUS; k++) begin
      if (!w_found && w_cand[k]) begin
        w_found = 1'b1;
        w_pick  = CW'(k);
      end
    end
  end

  assign w_busy     = (r_state == BUSY) && r_grant_valid;
  assign w_access   = w_busy && (ramstate_t'(bus.ramstate) == RAM_ACCESS);
  assign w_g_req    = r_grant_is_d ? w_dreq[r_grant_cpu] : bus.iREN[r_grant_cpu];
  assign w_withdraw = w_busy && !w_access && !w_g_req;
  // r_cnt holds cycles already waited; abort on the edge where it would reach TIMEOUT.
  assign w_tmo      = w_busy && !w_access && w_g_req && (r_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state       <= IDLE;
      r_grant_cpu   <= '0;
      r_grant_is_d  <= 1'b0;
      r_grant_valid <= 1'b0;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE) begin
        if (w_found) begin
          r_grant_cpu   <= w_pick;
          r_grant_is_d  <= w_any_d;
          r_grant_valid <= 1'b1;
          r_cnt         <= '0;
        end
      end else if (w_next_state == IDLE) begin
        r_grant_valid <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_tmo) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_found) w_next_state = BUSY;
      BUSY:    if (w_access || w_withdraw || w_tmo || !r_grant_valid) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.iwait    = '1;
    bus.dwait    = '1;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    if (w_busy) begin
      if (r_grant_is_d) begin
        bus.ramWEN   = bus.dWEN[r_grant_cpu];
        bus.ramREN   = bus.dREN[r_grant_cpu] & ~bus.dWEN[r_grant_cpu];
        bus.ramaddr  = bus.daddr[r_grant_cpu];
        bus.ramstore = bus.dstore[r_grant_cpu];
        if (w_access) bus.dwait[r_grant_cpu] = 1'b0;
      end else begin
        bus.ramREN   = bus.iREN[r_grant_cpu];
        bus.ramaddr  = bus.iaddr[r_grant_cpu];
        if (w_access) bus.iwait[r_grant_cpu] = 1'b0;
      end
    end
  end

  assign bus.iload   = {CPUS{bus.ramload}};
  assign bus.dload   = {CPUS{bus.ramload}};
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: stimulus queues expected grants/RAM ops, a monitor checks them.
module tb_memory_arbiter;
  localparam int unsigned CPUS = 2;

  logic clk = 1'b0;
  logic nrst;
  logic terr;

  always #5 clk = ~clk;

  memory_arbiter_if #(.CPUS(CPUS)) bus();

  memory_arbiter #(.CPUS(CPUS), .TIMEOUT(4)) dut (
    .CLK         (clk),
    .nRST        (nrst),
    .bus         (bus),
    .timeout_err (terr)
  );

  typedef struct {
    logic        is_d;
    int          cpu;
    logic        chk;
    logic [31:0] data;
  } gnt_t;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
  } ram_t;

  gnt_t gq[$];
  ram_t rq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int unsigned ram_lat   = 0;
  logic        ram_stuck = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic void exp_grant(logic is_d, int cpu, logic chk, logic [31:0] data);
    gnt_t g;
    g.is_d = is_d; g.cpu = cpu; g.chk = chk; g.data = data;
    gq.push_back(g);
  endfunction

  function automatic void exp_ram(logic wen, logic [31:0] addr, logic [31:0] store);
    ram_t r;
    r.wen = wen; r.addr = addr; r.store = store;
    rq.push_back(r);
  endfunction

  // RAM model: ACCESS after ram_lat BUSY cycles of an active request; load data is ~addr.
  initial begin
    int unsigned ram_cnt;
    ram_cnt      = 0;
    bus.ramstate = 2'd0;
    bus.ramload  = '0;
    forever begin
      @(negedge clk);
      if (bus.ramREN || bus.ramWEN) begin
        if (!ram_stuck && ram_cnt == ram_lat) begin
          bus.ramstate = 2'd2;
          bus.ramload  = ~bus.ramaddr;
        end else begin
          bus.ramstate = 2'd1;
        end
        ram_cnt++;
      end else begin
        bus.ramstate = 2'd0;
        ram_cnt      = 0;
      end
    end
  end

  task automatic pop_grant(input logic is_d, input int c);
    gnt_t g;
    if (gq.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_low: got unexpected %s wait low on cpu %0d, expected none",
               is_d ? "d" : "i", c);
    end else begin
      g = gq.pop_front();
      check("grant_class", 32'(is_d), 32'(g.is_d));
      check("grant_cpu", 32'(c), 32'(g.cpu));
      if (g.chk) check("load_data", is_d ? bus.dload[c] : bus.iload[c], g.data);
    end
  endtask

  initial begin
    ram_t e;
    forever begin
      @(negedge clk);
      #1;
      if (bus.ramstate == 2'd2 && (bus.ramREN || bus.ramWEN)) begin
        if (rq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL ram_op: got unexpected access addr %h, expected none", bus.ramaddr);
        end else begin
          e = rq.pop_front();
          check("ram_wen", 32'(bus.ramWEN), 32'(e.wen));
          check("ram_ren", 32'(bus.ramREN), 32'(!e.wen));
          check("ram_addr", bus.ramaddr, e.addr);
          if (e.wen) check("ram_store", bus.ramstore, e.store);
        end
      end
      for (int c = 0; c < CPUS; c++) begin
        if (bus.dwait[c] === 1'b0) pop_grant(1'b1, c);
        if (bus.iwait[c] === 1'b0) pop_grant(1'b0, c);
      end
    end
  end

  task automatic drain(input int max_cyc, input bit auto_drop);
    int k;
    k = 0;
    while ((gq.size() != 0 || rq.size() != 0) && k < max_cyc) begin
      @(negedge clk);
      #2;
      k++;
      if (auto_drop) begin
        for (int c = 0; c < CPUS; c++) begin
          if (bus.iwait[c] == 1'b0) bus.iREN[c] = 1'b0;
          if (bus.dwait[c] == 1'b0) begin
            bus.dREN[c] = 1'b0;
            bus.dWEN[c] = 1'b0;
          end
        end
      end
    end
    n_vec++;
    if (gq.size() != 0 || rq.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d grants and %0d ram ops outstanding, expected 0",
               gq.size(), rq.size());
    end
  endtask

  task automatic do_reset();
    nrst       = 1'b0;
    bus.iREN   = '0;
    bus.dREN   = '0;
    bus.dWEN   = '0;
    bus.iaddr  = '0;
    bus.daddr  = '0;
    bus.dstore = '0;
    ram_lat    = 0;
    ram_stuck  = 1'b0;
    @(negedge clk);
    #2;
    check("rst_iwait", 32'(bus.iwait), 32'h3);
    check("rst_dwait", 32'(bus.dwait), 32'h3);
    check("rst_ramREN", 32'(bus.ramREN), 32'h0);
    check("rst_ramWEN", 32'(bus.ramWEN), 32'h0);
    check("rst_ramaddr", bus.ramaddr, 32'h0);
    check("rst_ramstore", bus.ramstore, 32'h0);
    check("rst_timeout_err", 32'(terr), 32'h0);
    nrst = 1'b1;
    @(negedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected earlier finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned seq[4];
    int busy;
    bit seen;

    // 1: single fetch, ACCESS on first BUSY cycle
    do_reset();
    bus.iREN[0]  = 1'b1;
    bus.iaddr[0] = 32'h40;
    exp_grant(1'b0, 0, 1'b1, 32'hFFFF_FFBF);
    exp_ram(1'b0, 32'h40, 32'h0);
    #1;
    check("t1_req_cycle_iwait", 32'(bus.iwait[0]), 32'h1);
    check("t1_req_cycle_ramREN", 32'(bus.ramREN), 32'h0);
    @(negedge clk);
    #2;
    check("t1_iwait_low", 32'(bus.iwait[0]), 32'h0);
    check("t1_ramREN", 32'(bus.ramREN), 32'h1);
    check("t1_ramaddr", bus.ramaddr, 32'h40);
    bus.iREN[0] = 1'b0;
    @(negedge clk);
    #2;
    check("t1_iwait_one_cycle", 32'(bus.iwait[0]), 32'h1);
    drain(5, 1'b1);

    // 2: data write beats simultaneous fetch
    do_reset();
    bus.iREN[0]   = 1'b1;
    bus.iaddr[0]  = 32'h100;
    bus.dWEN[1]   = 1'b1;
    bus.daddr[1]  = 32'h80;
    bus.dstore[1] = 32'hDEAD_BEEF;
    exp_grant(1'b1, 1, 1'b0, 32'h0);
    exp_ram(1'b1, 32'h80, 32'hDEAD_BEEF);
    exp_grant(1'b0, 0, 1'b1, 32'hFFFF_FEFF);
    exp_ram(1'b0, 32'h100, 32'h0);
    drain(10, 1'b1);

    // 3: two continuous data readers, 3-cycle RAM latency
    do_reset();
`ifdef MEMARB_RR_EN
    seq = '{0, 1, 0, 1};
`else
    seq = '{0, 0, 0, 0};
`endif
    ram_lat      = 2;
    bus.daddr[0] = 32'h200;
    bus.daddr[1] = 32'h300;
    bus.dREN     = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_grant(1'b1, int'(seq[i]), 1'b1, (seq[i] == 1) ? 32'hFFFF_FCFF : 32'hFFFF_FDFF);
      exp_ram(1'b0, (seq[i] == 1) ? 32'h300 : 32'h200, 32'h0);
    end
    drain(40, 1'b0);
    bus.dREN = '0;
    @(negedge clk);
    #2;
    @(negedge clk);
    #2;
    check("t3_idle_ramREN", 32'(bus.ramREN), 32'h0);

    // 4: RAM stuck BUSY, TIMEOUT=4
    do_reset();
    ram_stuck    = 1'b1;
    bus.daddr[1] = 32'h400;
    bus.dREN[1]  = 1'b1;
    busy = 0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      #2;
      if (bus.ramREN) busy++;
      if (terr && !seen) begin
        seen        = 1'b1;
        bus.dREN[1] = 1'b0;
      end
    end
    check("t4_busy_cycles", 32'(busy), 32'd4);
    check("t4_timeout_err", 32'(terr), 32'h1);
    check("t4_dwait", 32'(bus.dwait), 32'h3);

    // 5: request withdrawn mid-BUSY, then rr must still favour cpu0
    do_reset();
    ram_stuck    = 1'b1;
    bus.daddr[0] = 32'h500;
    bus.dREN[0]  = 1'b1;
    @(negedge clk);
    #2;
    check("t5_busy_ramREN", 32'(bus.ramREN), 32'h1);
    @(negedge clk);
    #2;
    bus.dREN[0] = 1'b0;
    @(negedge clk);
    #2;
    check("t5_abort_ramREN", 32'(bus.ramREN), 32'h0);
    check("t5_abort_dwait", 32'(bus.dwait), 32'h3);
    check("t5_abort_iwait", 32'(bus.iwait), 32'h3);
    check("t5_timeout_err", 32'(terr), 32'h0);
    ram_stuck    = 1'b0;
    bus.daddr[1] = 32'h600;
    bus.dREN     = 2'b11;
    exp_grant(1'b1, 0, 1'b1, 32'hFFFF_FAFF);
    exp_ram(1'b0, 32'h500, 32'h0);
    exp_grant(1'b1, 1, 1'b1, 32'hFFFF_F9FF);
    exp_ram(1'b0, 32'h600, 32'h0);
    drain(12, 1'b1);

    // 6: reset pulsed during a write
    do_reset();
    ram_stuck     = 1'b1;
    bus.daddr[0]  = 32'h700;
    bus.dstore[0] = 32'h1234_5678;
    bus.dWEN[0]   = 1'b1;
    @(negedge clk);
    #2;
    check("t6_busy_ramWEN", 32'(bus.ramWEN), 32'h1);
    check("t6_busy_ramstore", bus.ramstore, 32'h1234_5678);
    nrst = 1'b0;
    #1;
    check("t6_rst_ramWEN", 32'(bus.ramWEN), 32'h0);
    check("t6_rst_ramaddr", bus.ramaddr, 32'h0);
    check("t6_rst_dwait", 32'(bus.dwait), 32'h3);
    check("t6_rst_iwait", 32'(bus.iwait), 32'h3);
    bus.dWEN[0] = 1'b0;
    ram_stuck   = 1'b0;
    @(negedge clk);
    #2;
    nrst = 1'b1;
    @(negedge clk);
    #2;
    check("t6_post_ramWEN", 32'(bus.ramWEN), 32'h0);
    check("t6_post_dwait", 32'(bus.dwait), 32'h3);
    bus.daddr[0] = 32'h800;
    bus.dREN[0]  = 1'b1;
    exp_grant(1'b1, 0, 1'b1, 32'hFFFF_F7FF);
    exp_ram(1'b0, 32'h800, 32'h0);
    drain(10, 1'b1);

    @(negedge clk);
    #2;
    check("end_grant_queue", 32'(gq.size()), 32'h0);
    check("end_ram_queue", 32'(rq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
